// File: rtl/sample_line_cache.sv
// Per-channel single-line sample cache with a round-robin, one-outstanding SDRAM line fetcher.
// Optional prefetch of the following line per channel is enabled with SAMPLE_CACHE_PREFETCH_EN.
module sample_line_cache #(
  parameter int          CHANNELS   = 8,
  parameter int          ADDR_W     = 20,
  parameter int          LINE_BYTES = 8,
  parameter logic [24:0] BASE_ADDR  = 25'h0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rd,
  input  logic [$clog2(CHANNELS)-1:0] index,
  input  logic [ADDR_W-1:0]           addr,
  output logic                        valid,
  output logic [7:0]                  dout,
  output logic [24:0]                 sdr_addr,
  output logic                        sdr_req,
  input  logic [8*LINE_BYTES-1:0]     sdr_data,
  input  logic                        sdr_rdy
);

  localparam int IDX_W = $clog2(CHANNELS);
  localparam int OFF   = $clog2(LINE_BYTES);
  localparam int TAG_W = ADDR_W - OFF;
  localparam int LW    = 8 * LINE_BYTES;

  typedef enum logic [1:0] {
    ST_INVALID,
    ST_PENDING,
    ST_FETCHING,
    ST_VALID
  } line_state_t;

  logic [TAG_W-1:0] tag_q  [CHANNELS];
  logic [LW-1:0]    data_q [CHANNELS];
  line_state_t      st_q   [CHANNELS];

  logic             outstanding_q;
  logic [IDX_W-1:0] fetch_ch_q;
  logic [TAG_W-1:0] fetch_tag_q;
  logic [IDX_W-1:0] rr_q;

`ifdef SAMPLE_CACHE_PREFETCH_EN
  logic [TAG_W-1:0] pf_tag_q  [CHANNELS];
  logic [LW-1:0]    pf_data_q [CHANNELS];
  line_state_t      pf_st_q   [CHANNELS];
  logic             fetch_pf_q;
  logic [CHANNELS-1:0] pf_pend;
  logic             grant_pf;
  logic             fill_pf;
  logic             pf_fill_now;
`endif

  logic [TAG_W-1:0]    rd_tag;
  logic [OFF-1:0]      rd_off;
  logic                rd_hit;
  logic [CHANNELS-1:0] dem_pend;
  logic                grant;
  logic [IDX_W-1:0]    grant_ch;
  logic [TAG_W-1:0]    grant_tag;
  logic [IDX_W-1:0]    cand;
  logic [ADDR_W-1:0]   grant_line;
  logic                fill_dem;

  assign rd_tag     = addr[ADDR_W-1:OFF];
  assign rd_off     = addr[OFF-1:0];
  assign rd_hit     = (tag_q[index] == rd_tag);
  assign grant_line = {grant_tag, {OFF{1'b0}}};

`ifdef SAMPLE_CACHE_PREFETCH_EN
  assign fill_dem = !fetch_pf_q && (st_q[fetch_ch_q] == ST_FETCHING) &&
                    (tag_q[fetch_ch_q] == fetch_tag_q);
  assign fill_pf  = fetch_pf_q && (pf_st_q[fetch_ch_q] == ST_FETCHING) &&
                    (pf_tag_q[fetch_ch_q] == fetch_tag_q);
  assign pf_fill_now = sdr_rdy && outstanding_q && fetch_pf_q && (fetch_ch_q == index);
`else
  assign fill_dem = (st_q[fetch_ch_q] == ST_FETCHING) && (tag_q[fetch_ch_q] == fetch_tag_q);
`endif

  // A channel being read this cycle is held out of arbitration so the read's tag/state update wins.
  always_comb begin
    dem_pend = '0;
`ifdef SAMPLE_CACHE_PREFETCH_EN
    pf_pend = '0;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      dem_pend[i] = !outstanding_q && (st_q[i] == ST_PENDING) && !(rd && (index == IDX_W'(i)));
`ifdef SAMPLE_CACHE_PREFETCH_EN
      pf_pend[i] = !outstanding_q && (pf_st_q[i] == ST_PENDING) && !(rd && (index == IDX_W'(i)));
`endif
    end
  end

  // Round-robin search starting just after the last granted channel; demand lines beat prefetches.
  always_comb begin
    grant     = 1'b0;
    grant_ch  = '0;
    grant_tag = '0;
    cand      = '0;
`ifdef SAMPLE_CACHE_PREFETCH_EN
    grant_pf  = 1'b0;
`endif
    for (int k = 1; k <= CHANNELS; k++) begin
      cand = rr_q + IDX_W'(k);
      if (!grant && dem_pend[cand]) begin
        grant     = 1'b1;
        grant_ch  = cand;
        grant_tag = tag_q[cand];
      end
    end
`ifdef SAMPLE_CACHE_PREFETCH_EN
    for (int k = 1; k <= CHANNELS; k++) begin
      cand = rr_q + IDX_W'(k);
      if (!grant && pf_pend[cand]) begin
        grant     = 1'b1;
        grant_pf  = 1'b1;
        grant_ch  = cand;
        grant_tag = pf_tag_q[cand];
      end
    end
`endif
  end

  // Fill, grant and read updates in that order, so a read's later assignment takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
        st_q[i]   <= ST_INVALID;
`ifdef SAMPLE_CACHE_PREFETCH_EN
        pf_tag_q[i]  <= '0;
        pf_data_q[i] <= '0;
        pf_st_q[i]   <= ST_INVALID;
`endif
      end
      outstanding_q <= 1'b0;
      fetch_ch_q    <= '0;
      fetch_tag_q   <= '0;
      rr_q          <= '0;
      valid         <= 1'b0;
      dout          <= 8'h00;
      sdr_req       <= 1'b0;
      sdr_addr      <= 25'h0;
`ifdef SAMPLE_CACHE_PREFETCH_EN
      fetch_pf_q    <= 1'b0;
`endif
    end else begin
      sdr_req <= 1'b0;

      if (sdr_rdy && outstanding_q) begin
        outstanding_q <= 1'b0;
        if (fill_dem) begin
          data_q[fetch_ch_q] <= sdr_data;
          st_q[fetch_ch_q]   <= ST_VALID;
`ifdef SAMPLE_CACHE_PREFETCH_EN
          pf_tag_q[fetch_ch_q] <= tag_q[fetch_ch_q] + TAG_W'(1);
          pf_st_q[fetch_ch_q]  <= ST_PENDING;
`endif
        end
`ifdef SAMPLE_CACHE_PREFETCH_EN
        if (fill_pf) begin
          pf_data_q[fetch_ch_q] <= sdr_data;
          pf_st_q[fetch_ch_q]   <= ST_VALID;
        end
`endif
      end

      if (grant) begin
        sdr_req       <= 1'b1;
        sdr_addr      <= BASE_ADDR + 25'(grant_line);
        outstanding_q <= 1'b1;
        fetch_ch_q    <= grant_ch;
        fetch_tag_q   <= grant_tag;
        rr_q          <= grant_ch;
`ifdef SAMPLE_CACHE_PREFETCH_EN
        fetch_pf_q    <= grant_pf;
        if (grant_pf) pf_st_q[grant_ch] <= ST_FETCHING;
        else          st_q[grant_ch]    <= ST_FETCHING;
`else
        st_q[grant_ch] <= ST_FETCHING;
`endif
      end

      if (rd) begin
        if (rd_hit) begin
          if (st_q[index] == ST_VALID) begin
            valid <= 1'b1;
            dout  <= data_q[index][{rd_off, 3'b000} +: 8];
          end else begin
            valid <= 1'b0;
            if (st_q[index] == ST_INVALID) st_q[index] <= ST_PENDING;
          end
        end else begin
          tag_q[index] <= rd_tag;
          st_q[index]  <= ST_PENDING;
          valid        <= 1'b0;
`ifdef SAMPLE_CACHE_PREFETCH_EN
          // Promotion does not queue a further prefetch; the next demand fill does that.
          if ((pf_tag_q[index] == rd_tag) && (pf_st_q[index] != ST_INVALID)) begin
            pf_st_q[index] <= ST_INVALID;
            case (pf_st_q[index])
              ST_VALID: begin
                data_q[index] <= pf_data_q[index];
                st_q[index]   <= ST_VALID;
                valid         <= 1'b1;
                dout          <= pf_data_q[index][{rd_off, 3'b000} +: 8];
              end
              ST_FETCHING: begin
                if (!pf_fill_now) begin
                  st_q[index] <= ST_FETCHING;
                  fetch_pf_q  <= 1'b0;
                end
              end
              default: ;
            endcase
          end
`endif
        end
      end
    end
  end

endmodule
